// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer and its ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB2B  = 2'b00,
        OP_LTX    = 2'b01,
        OP_ADDB   = 2'b10,
        OP_ADDCHK = 2'b11
    } alu_op_e;

    localparam int unsigned ST_ERR  = 0;
    localparam int unsigned ST_EVEN = 1;
    localparam int unsigned ST_ONES = 2;
    localparam int unsigned ST_OVF  = 3;

    localparam int unsigned ALU_N = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHold
    } seq_state_e;

    typedef struct packed {
        alu_op_e          op;
        logic [ALU_N-1:0] a;
        logic [ALU_N-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; head is read combinationally.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time and registers each response.
// Optional command tagging is enabled by defining ALU_SEQ_TAG_EN.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
`ifdef ALU_SEQ_TAG_EN
    ,
    parameter int unsigned TAG_W = 4
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [N-1:0]      i_cmd_a,
    input  logic [N-1:0]      i_cmd_b,
`ifdef ALU_SEQ_TAG_EN
    input  logic [TAG_W-1:0]  i_cmd_tag,
    output logic [TAG_W-1:0]  o_rsp_tag,
`endif
    output logic [1:0]        o_alu_op,
    output logic [N-1:0]      o_alu_a,
    output logic [N-1:0]      o_alu_b,
    input  logic [N-1:0]      i_alu_result,
    input  logic [3:0]        i_alu_status,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [N-1:0]      o_rsp_result,
    output logic [3:0]        o_rsp_status,
    output logic              o_busy,
    output logic [ERR_W-1:0]  o_err_count
);

    localparam int unsigned CMD_W = 2 + 2 * N;
`ifdef ALU_SEQ_TAG_EN
    localparam int unsigned ENTRY_W = CMD_W + TAG_W;
`else
    localparam int unsigned ENTRY_W = CMD_W;
`endif
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;

    alu_op_e            r_alu_op;
    logic [N-1:0]       r_alu_a;
    logic [N-1:0]       r_alu_b;
    logic               r_rsp_valid;
    logic [N-1:0]       r_rsp_result;
    logic [3:0]         r_rsp_status;
    logic [ERR_W-1:0]   r_err_count;

`ifdef ALU_SEQ_TAG_EN
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_rsp_tag;

    assign w_push_data = {i_cmd_tag, i_cmd_op, i_cmd_a, i_cmd_b};
    assign o_rsp_tag   = r_rsp_tag;
`else
    assign w_push_data = {i_cmd_op, i_cmd_a, i_cmd_b};
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (i_cmd_valid),
        .i_pop     (w_pop),
        .i_data    (w_push_data),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign o_cmd_ready  = !w_full;
    assign o_busy       = (r_state != StIdle) || (w_count != '0);
    assign o_alu_op     = r_alu_op;
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_status = r_rsp_status;
    assign o_err_count  = r_err_count;

    // A pop in HOLD chains straight into ISSUE, giving one response per 3 cycles.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: w_state_next = StWait;
            StWait:  w_state_next = StHold;
            StHold: begin
                if (i_rsp_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StIssue;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_alu_op     <= OP_SUB2B;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= '0;
            r_err_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_alu_op <= alu_op_e'(w_head[CMD_W-1 -: 2]);
                r_alu_a  <= w_head[2*N-1 -: N];
                r_alu_b  <= w_head[N-1:0];
            end
            if (r_state == StWait) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= i_alu_result;
                r_rsp_status <= i_alu_status;
                if (i_alu_status[ST_ERR] && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (r_state == StHold && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_TAG_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tag     <= '0;
            r_rsp_tag <= '0;
        end else begin
            if (w_pop) r_tag <= w_head[ENTRY_W-1 -: TAG_W];
            if (r_state == StWait) r_rsp_tag <= r_tag;
        end
    end
`endif

endmodule
